pe_window_addr_gen: RTL and testbench
=====================================

// Module: pe_window_addr_gen
// PURPOSE
//  Parametrised sliding-window address sequencer for the Eyeriss PE datapath.
//  Replaces the per-loop filter/stride/write counters with one nested-loop engine.
//  Emits one (ifmap_addr, filter_addr, psum_addr) beat per handshake over three loops.
//  Loop order, innermost first: filter tap k, filter index f, window start s.
//  Sits between the PE controller (start/done) and the ifmap/filter/psum scratchpads.
// PARAMETERS
//  IFMAP_AW   4  ifmap scratchpad address width; also the width of input_len and stride
//  FILTER_AW  4  filter scratchpad address width; also the width of filter_size
//  NF_W       2  filter-count width; up to 2**NF_W filters
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          synchronous, active-high reset
//  start        in   1          pulse; latches the config while IDLE
//  filter_size  in   FILTER_AW  taps per filter, 1..2**FILTER_AW-1
//  num_filters  in   NF_W+1     filters per window, 1..2**NF_W
//  stride       in   IFMAP_AW   window step, >=1
//  input_len    in   IFMAP_AW   valid ifmap entries, >=filter_size
//  ready        in   1          consumer accepts the current beat
//  valid        out  1          current beat is valid
//  ifmap_addr   out  IFMAP_AW   s + k
//  filter_addr  out  FILTER_AW  f*filter_size + k, truncated to FILTER_AW
//  psum_addr    out  NF_W       f
//  last_tap     out  1          valid && k==filter_size-1 (psum write strobe)
//  window_done  out  1          last_tap && f==num_filters-1
//  busy         out  1          state != IDLE
//  done         out  1          one-cycle pulse after the final beat is accepted
//  cfg_err      out  1          one-cycle pulse: start carried an illegal config
// BEHAVIOUR
//  Reset: state=IDLE; k, f, s = 0; all outputs 0; latched config cleared.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start with a legal config, latch the config, zero k/f/s, go to RUN next cycle.
//   IDLE, illegal config: filter_size==0, num_filters==0, stride==0, or filter_size>input_len.
//     Pulse cfg_err the next cycle and stay in IDLE.
//   RUN: valid=1; addresses are registered from k/f/s with 0-cycle output latency.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Handshake: the beat advances only on valid&&ready.
//   While ready=0, all outputs hold stable; no beat is dropped or duplicated.
//  Advance on each handshake:
//   if k<fs-1: k++.
//   else if f<nf-1: k=0, f++.
//   else: k=0, f=0; test the next window.
//  Next-window test: computed in IFMAP_AW+2 bits, n = s + stride + fs - 1.
//   If n <= input_len-1: s += stride.
//   Otherwise the last beat has completed: go to DONE.
//   The extra bits guarantee no wrap; an overflow always means the run is finished.
//  filter_addr uses a running base register (base += fs per f step), not a multiplier.
//   Wrap-around at 2**FILTER_AW is legal and silent.
//  start while busy is ignored; the latched config never changes mid-run.
//  rst during RUN or DONE: returns to IDLE next cycle and suppresses the done pulse.
//  Single-beat run (fs=1, nf=1, input_len=1): one beat, then done.
//  The total beat count is fs*nf*W, where W = floor((input_len-fs)/stride)+1.
// STRUCTURE
//  Shared package pe_pkg: state encodings IDLE/RUN/DONE, a cfg_t bundle,
//   and localparam EXT_W = IFMAP_AW+2.
//  One sub-module, pe_wrap_cnt #(W): sync-rst counter.
//   Ports: clr, en, max; outputs q and wrap = en && (q==max); q returns to 0 on wrap.
//   Used three times, for k, f and the window index.
//   s and base are separate accumulators clocked by the wrap strobes.
// TESTING
//  1. fs=3, nf=1, stride=1, len=5, ready=1:
//     ifmap 0,1,2,1,2,3,2,3,4; 9 beats; done pulse 1 cycle after the last beat.
//  2. fs=3, nf=1, stride=2, len=6:
//     windows s=0 and s=2 only; 6 beats; s=4 is rejected (4+3-1=6>5).
//  3. fs=2, nf=2, stride=1, len=3:
//     (ifmap,filter,psum) = (0,0,0)(1,1,0)(0,2,1)(1,3,1)(1,0,0)(2,1,0)(1,2,1)(2,3,1).
//     window_done on beats 4 and 8.
//  4. Test 1 with ready toggled randomly:
//     identical address sequence; outputs hold during every ready=0 cycle.
//  5. start with fs=4, len=3:
//     cfg_err pulse, busy stays 0. Then start with stride=0: cfg_err again.
//  6. rst asserted at beat 5 of test 1:
//     next cycle busy=0, valid=0, no done. A fresh start then replays from ifmap 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the Eyeriss PE window address sequencer.
package pe_pkg;

    // Default geometry of the PE scratchpads.
    localparam int IFMAP_AW_DEF  = 4;
    localparam int FILTER_AW_DEF = 4;
    localparam int NF_W_DEF      = 2;

    // Width of the next-window test; two guard bits keep s + stride + fs - 1 from wrapping.
    localparam int EXT_W = IFMAP_AW_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Configuration bundle as presented by the PE controller at start.
    typedef struct packed {
        logic [FILTER_AW_DEF-1:0] filter_size;
        logic [NF_W_DEF:0]        num_filters;
        logic [IFMAP_AW_DEF-1:0]  stride;
        logic [IFMAP_AW_DEF-1:0]  input_len;
    } cfg_t;

endpackage

// File: rtl/pe_wrap_cnt.sv
// Wrapping up-counter: counts on en, returns to 0 when it steps past max.
module pe_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign wrap = en && (q_q == max);
    assign q    = q_q;

    // Next count: clear wins, otherwise increment or wrap to zero.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = wrap ? '0 : q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/pe_window_addr_gen.sv
// Sliding-window address sequencer: nested loops over tap k, filter f and window start s.
module pe_window_addr_gen
    import pe_pkg::*;
#(
    parameter int IFMAP_AW  = 4,
    parameter int FILTER_AW = 4,
    parameter int NF_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [FILTER_AW-1:0] filter_size,
    input  logic [NF_W:0]        num_filters,
    input  logic [IFMAP_AW-1:0]  stride,
    input  logic [IFMAP_AW-1:0]  input_len,
    input  logic                 ready,
    output logic                 valid,
    output logic [IFMAP_AW-1:0]  ifmap_addr,
    output logic [FILTER_AW-1:0] filter_addr,
    output logic [NF_W-1:0]      psum_addr,
    output logic                 last_tap,
    output logic                 window_done,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int XW = ((IFMAP_AW > FILTER_AW) ? IFMAP_AW : FILTER_AW) + 2;
    localparam logic [IFMAP_AW-1:0] WIN_MAX = '1;

    state_e state_q, state_d;

    logic [FILTER_AW-1:0] fs_q;
    logic [NF_W:0]        nf_q;
    logic [IFMAP_AW-1:0]  stride_q;
    logic [IFMAP_AW-1:0]  len_q;
    logic [IFMAP_AW-1:0]  s_q, s_d;
    logic [FILTER_AW-1:0] base_q, base_d;
    logic                 cfg_err_q;

    logic                 illegal, start_ok, adv;
    logic [FILTER_AW-1:0] fs_m1;
    logic [NF_W:0]        nf_m1;
    logic [FILTER_AW-1:0] k_q;
    logic [NF_W-1:0]      f_q;
    logic [IFMAP_AW-1:0]  win_q;
    logic                 k_wrap, f_wrap, win_wrap;
    logic [XW-1:0]        n_next;
    logic                 over, win_at_max, finish;

    assign illegal  = (filter_size == '0) || (num_filters == '0) || (stride == '0) ||
                      (XW'(filter_size) > XW'(input_len));
    assign start_ok = (state_q == IDLE) && start && !illegal;
    assign valid    = (state_q == RUN);
    assign adv      = valid && ready;

    assign fs_m1 = fs_q - FILTER_AW'(1);
    assign nf_m1 = nf_q - (NF_W + 1)'(1);

    pe_wrap_cnt #(.W(FILTER_AW)) u_k_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (adv),
        .max  (fs_m1),
        .q    (k_q),
        .wrap (k_wrap)
    );

    pe_wrap_cnt #(.W(NF_W)) u_f_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (k_wrap),
        .max  (nf_m1[NF_W-1:0]),
        .q    (f_q),
        .wrap (f_wrap)
    );

    pe_wrap_cnt #(.W(IFMAP_AW)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (f_wrap),
        .max  (WIN_MAX),
        .q    (win_q),
        .wrap (win_wrap)
    );

    // Would the next window's last tap still land inside the ifmap? Guard bits prevent wrap.
    assign n_next     = XW'(s_q) + XW'(stride_q) + XW'(fs_q) - XW'(1);
    assign over       = (n_next >= XW'(len_q));
    // Window index saturating is a backstop; with legal configs `over` always fires first.
    assign win_at_max = (win_q == WIN_MAX);
    assign finish     = f_wrap && (over || win_at_max);

    // Window start and filter base accumulators, stepped by the counter wrap strobes.
    always_comb begin
        s_d    = s_q;
        base_d = base_q;
        if (start_ok) begin
            s_d    = '0;
            base_d = '0;
        end else begin
            if (f_wrap && !over && !win_wrap) begin
                s_d = s_q + stride_q;
            end
            if (k_wrap) begin
                base_d = f_wrap ? '0 : base_q + fs_q;
            end
        end
    end

    // Accumulator, latched-config and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            base_q    <= '0;
            fs_q      <= '0;
            nf_q      <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            base_q    <= base_d;
            cfg_err_q <= (state_q == IDLE) && start && illegal;
            if (start_ok) begin
                fs_q     <= filter_size;
                nf_q     <= num_filters;
                stride_q <= stride;
                len_q    <= input_len;
            end
        end
    end

    // FSM next state: IDLE -> RUN on legal start, RUN -> DONE after the final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (finish)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ifmap_addr  = valid ? (s_q + IFMAP_AW'(k_q)) : '0;
    assign filter_addr = valid ? (base_q + k_q) : '0;
    assign psum_addr   = valid ? f_q : '0;
    assign last_tap    = valid && (k_q == fs_m1);
    assign window_done = last_tap && ({1'b0, f_q} == nf_m1);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pe_window_addr_gen.sv
// Directed bench for pe_window_addr_gen with hand-computed address sequences.
module tb_pe_window_addr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] filter_size = '0;
    logic [2:0] num_filters = '0;
    logic [3:0] stride = '0;
    logic [3:0] input_len = '0;
    logic       ready = 1'b0;
    logic       valid;
    logic [3:0] ifmap_addr;
    logic [3:0] filter_addr;
    logic [1:0] psum_addr;
    logic       last_tap, window_done, busy, done, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    int  b_if[$];
    int  b_fa[$];
    int  b_ps[$];
    int  b_lt[$];
    int  b_wd[$];
    int  last_cyc, done_cyc;
    bit  done_seen;

    pe_window_addr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filter_size (filter_size),
        .num_filters (num_filters),
        .stride      (stride),
        .input_len   (input_len),
        .ready       (ready),
        .valid       (valid),
        .ifmap_addr  (ifmap_addr),
        .filter_addr (filter_addr),
        .psum_addr   (psum_addr),
        .last_tap    (last_tap),
        .window_done (window_done),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fs, input int nf, input int st, input int len);
        filter_size = 4'(fs);
        num_filters = 3'(nf);
        stride      = 4'(st);
        input_len   = 4'(len);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Runs with ready high, recording each accepted beat, until done or the cycle budget runs out.
    task automatic collect(input int max_cyc, input bit poke);
        b_if.delete(); b_fa.delete(); b_ps.delete(); b_lt.delete(); b_wd.delete();
        done_seen = 1'b0;
        last_cyc  = -1;
        done_cyc  = -1;
        for (int c = 0; c < max_cyc; c++) begin
            ready = 1'b1;
            if (poke && c == 2) begin
                start = 1'b1; filter_size = 4'd1; num_filters = 3'd1; stride = 4'd1; input_len = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = c;
                break;
            end
            if (valid && ready) begin
                b_if.push_back(int'(ifmap_addr));
                b_fa.push_back(int'(filter_addr));
                b_ps.push_back(int'(psum_addr));
                b_lt.push_back(int'(last_tap));
                b_wd.push_back(int'(window_done));
                last_cyc = c;
            end
            tick();
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_vec++;
        if ({valid, busy, done, cfg_err, last_tap, window_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {valid, busy, done, cfg_err, last_tap, window_done});
        end
        n_vec++;
        if ({ifmap_addr, filter_addr, psum_addr} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_addr got %h expected 0", {ifmap_addr, filter_addr, psum_addr});
        end
    endtask

    task automatic test_basic();
        int exp_if[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        int exp_fa[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        int exp_lt[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        do_start(3, 1, 1, 5);
        collect(40, 1'b0);
        n_vec++;
        if (b_if.size() !== 9) begin
            n_err++; $display("FAIL t1_count got %0d expected 9", b_if.size());
        end
        for (int i = 0; i < 9; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            int a_fa = (i < b_fa.size()) ? b_fa[i] : -1;
            int a_lt = (i < b_lt.size()) ? b_lt[i] : -1;
            int a_ps = (i < b_ps.size()) ? b_ps[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t1_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
            n_vec++;
            if (a_fa !== exp_fa[i]) begin n_err++; $display("FAIL t1_filter[%0d] got %0d expected %0d", i, a_fa, exp_fa[i]); end
            n_vec++;
            if (a_lt !== exp_lt[i]) begin n_err++; $display("FAIL t1_last_tap[%0d] got %0d expected %0d", i, a_lt, exp_lt[i]); end
            n_vec++;
            if (a_ps !== 0) begin n_err++; $display("FAIL t1_psum[%0d] got %0d expected 0", i, a_ps); end
        end
        n_vec++;
        if (!done_seen || done_cyc !== last_cyc + 1) begin
            n_err++; $display("FAIL t1_done_latency got %0d expected %0d", done_cyc, last_cyc + 1);
        end
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_err++; $display("FAIL t1_done_width got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_stride2();
        int exp_if[6] = '{0, 1, 2, 2, 3, 4};
        int exp_fa[6] = '{0, 1, 2, 0, 1, 2};
        do_start(3, 1, 2, 6);
        collect(40, 1'b0);
        n_vec++;
        if (b_if.size() !== 6) begin
            n_err++; $display("FAIL t2_count got %0d expected 6", b_if.size());
        end
        for (int i = 0; i < 6; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            int a_fa = (i < b_fa.size()) ? b_fa[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t2_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
            n_vec++;
            if (a_fa !== exp_fa[i]) begin n_err++; $display("FAIL t2_filter[%0d] got %0d expected %0d", i, a_fa, exp_fa[i]); end
        end
        n_vec++;
        if (!done_seen) begin n_err++; $display("FAIL t2_done got 0 expected 1"); end
    endtask

    task automatic test_multi_filter();
        int exp_if[8] = '{0, 1, 0, 1, 1, 2, 1, 2};
        int exp_fa[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_ps[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int exp_wd[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        do_start(2, 2, 1, 3);
        collect(40, 1'b0);
        n_vec++;
        if (b_if.size() !== 8) begin
            n_err++; $display("FAIL t3_count got %0d expected 8", b_if.size());
        end
        for (int i = 0; i < 8; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            int a_fa = (i < b_fa.size()) ? b_fa[i] : -1;
            int a_ps = (i < b_ps.size()) ? b_ps[i] : -1;
            int a_wd = (i < b_wd.size()) ? b_wd[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t3_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
            n_vec++;
            if (a_fa !== exp_fa[i]) begin n_err++; $display("FAIL t3_filter[%0d] got %0d expected %0d", i, a_fa, exp_fa[i]); end
            n_vec++;
            if (a_ps !== exp_ps[i]) begin n_err++; $display("FAIL t3_psum[%0d] got %0d expected %0d", i, a_ps, exp_ps[i]); end
            n_vec++;
            if (a_wd !== exp_wd[i]) begin n_err++; $display("FAIL t3_window_done[%0d] got %0d expected %0d", i, a_wd, exp_wd[i]); end
        end
    endtask

    task automatic test_ready_toggle();
        int   exp_if[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        bit   held = 1'b0;
        int   holds = 0;
        logic [10:0] snap = '0;
        b_if.delete();
        done_seen = 1'b0;
        do_start(3, 1, 1, 5);
        for (int c = 0; c < 200; c++) begin
            if (held) begin
                holds++;
                n_vec++;
                if ({valid, ifmap_addr, filter_addr, psum_addr} !== snap) begin
                    n_err++;
                    $display("FAIL t4_hold cycle %0d got %h expected %h", c,
                             {valid, ifmap_addr, filter_addr, psum_addr}, snap);
                end
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            ready = (c < 2) ? 1'b0 : 1'(($urandom_range(0, 1)));
            if (valid && ready) b_if.push_back(int'(ifmap_addr));
            held = valid && !ready;
            snap = {valid, ifmap_addr, filter_addr, psum_addr};
            tick();
        end
        ready = 1'b0;
        tick();
        n_vec++;
        if (!done_seen || holds == 0) begin
            n_err++; $display("FAIL t4_done_and_stalls got done=%0d holds=%0d expected done=1 holds>0", done_seen, holds);
        end
        n_vec++;
        if (b_if.size() !== 9) begin
            n_err++; $display("FAIL t4_count got %0d expected 9", b_if.size());
        end
        for (int i = 0; i < 9; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t4_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
        end
    endtask

    task automatic test_cfg_err();
        do_start(4, 1, 1, 3);
        n_vec++;
        if ({cfg_err, busy} !== 2'b10) begin
            n_err++; $display("FAIL t5_fs_gt_len got cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
        end
        tick();
        n_vec++;
        if ({cfg_err, busy} !== 2'b00) begin
            n_err++; $display("FAIL t5_pulse_width got cfg_err=%b busy=%b expected 0 0", cfg_err, busy);
        end
        do_start(1, 1, 0, 4);
        n_vec++;
        if ({cfg_err, busy} !== 2'b10) begin
            n_err++; $display("FAIL t5_stride0 got cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
        end
        tick();
        do_start(2, 0, 1, 4);
        n_vec++;
        if ({cfg_err, busy} !== 2'b10) begin
            n_err++; $display("FAIL t5_nf0 got cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        int  exp_if[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        bit  saw_done = 1'b0;
        do_start(3, 1, 1, 5);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (ifmap_addr !== 4'd2 || valid !== 1'b1) begin
            n_err++; $display("FAIL t6_beat5 got ifmap=%0d valid=%b expected 2 1", ifmap_addr, valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({busy, valid, done} !== 3'b000) begin
            n_err++; $display("FAIL t6_after_rst got busy=%b valid=%b done=%b expected 0 0 0", busy, valid, done);
        end
        for (int i = 0; i < 3; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++; $display("FAIL t6_no_done got 1 expected 0");
        end
        do_start(3, 1, 1, 5);
        collect(40, 1'b0);
        n_vec++;
        if (b_if.size() !== 9) begin
            n_err++; $display("FAIL t6_replay_count got %0d expected 9", b_if.size());
        end
        for (int i = 0; i < 9; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t6_replay_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
        end
    endtask

    task automatic test_start_ignored();
        int exp_if[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        do_start(3, 1, 1, 5);
        collect(40, 1'b1);
        n_vec++;
        if (b_if.size() !== 9 || !done_seen) begin
            n_err++; $display("FAIL t7_busy_start_count got %0d expected 9", b_if.size());
        end
        for (int i = 0; i < 9; i++) begin
            int a_if = (i < b_if.size()) ? b_if[i] : -1;
            n_vec++;
            if (a_if !== exp_if[i]) begin n_err++; $display("FAIL t7_ifmap[%0d] got %0d expected %0d", i, a_if, exp_if[i]); end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL t7_idle_after got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single_beat();
        do_start(1, 1, 1, 1);
        collect(10, 1'b0);
        n_vec++;
        if (b_if.size() !== 1) begin
            n_err++; $display("FAIL t8_count got %0d expected 1", b_if.size());
        end else begin
            n_vec++;
            if ({b_if[0], b_fa[0], b_lt[0], b_wd[0]} !== {32'd0, 32'd0, 32'd1, 32'd1}) begin
                n_err++; $display("FAIL t8_beat got if=%0d fa=%0d lt=%0d wd=%0d expected 0 0 1 1",
                                  b_if[0], b_fa[0], b_lt[0], b_wd[0]);
            end
        end
        n_vec++;
        if (!done_seen || done_cyc !== last_cyc + 1) begin
            n_err++; $display("FAIL t8_done_latency got %0d expected %0d", done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_filter_wrap();
        do_start(5, 4, 1, 5);
        collect(60, 1'b0);
        n_vec++;
        if (b_fa.size() !== 20) begin
            n_err++; $display("FAIL t9_count got %0d expected 20", b_fa.size());
        end else begin
            n_vec++;
            if (b_fa[15] !== 15) begin n_err++; $display("FAIL t9_filter[15] got %0d expected 15", b_fa[15]); end
            n_vec++;
            if (b_fa[16] !== 0) begin n_err++; $display("FAIL t9_filter[16] got %0d expected 0", b_fa[16]); end
            n_vec++;
            if (b_fa[19] !== 3) begin n_err++; $display("FAIL t9_filter[19] got %0d expected 3", b_fa[19]); end
            n_vec++;
            if ({b_ps[19], b_wd[19], b_if[19]} !== {32'd3, 32'd1, 32'd4}) begin
                n_err++; $display("FAIL t9_last got psum=%0d wd=%0d if=%0d expected 3 1 4", b_ps[19], b_wd[19], b_if[19]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride2();
        test_multi_filter();
        test_ready_toggle();
        test_cfg_err();
        test_reset_midrun();
        test_start_ignored();
        test_single_beat();
        test_filter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
